// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready bundle between IF/ID register, immediate generator and ID/EX register
interface imm_gen_pipe_if #(parameter int XLEN = 64, parameter int CNT_W = 8);
  logic [31:0]      inst_i;
  logic             valid_i;
  logic             ready_o;
  logic [XLEN-1:0]  sal_o;
  logic [2:0]       fmt_o;
  logic             illegal_o;
  logic             valid_o;
  logic             ready_i;
  logic             clr_cnt_i;
  logic [CNT_W-1:0] illegal_cnt_o;
  modport slave (
    input  inst_i, valid_i, ready_i, clr_cnt_i,
    output ready_o, sal_o, fmt_o, illegal_o, valid_o, illegal_cnt_o
  );
  modport master (
    output inst_i, valid_i, ready_i, clr_cnt_i,
    input  ready_o, sal_o, fmt_o, illegal_o, valid_o, illegal_cnt_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with 2-entry skid buffer and illegal-opcode counter
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  imm_gen_pipe_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] sal;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;
  logic [31:0]      i;
  logic [6:0]       op;
  logic [31:0]      imm;
  ent_t             dec, out_q, out_d, skid_q, skid_d;
  logic             out_v_q, out_v_d, skid_v_q, skid_v_d, ready_q, ready_d, acc, drn;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    i = bus.inst_i;
    op = i[6:0];
    dec.fmt = (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 ||
               (XLEN == 64 && op == 7'b0011011)) ? 3'd1 :
              op == 7'b0100011 ? 3'd2 :
              op == 7'b1100011 ? 3'd3 :
              (op == 7'b0110111 || op == 7'b0010111) ? 3'd4 :
              op == 7'b1101111 ? 3'd5 : 3'd0;
    imm = dec.fmt == 3'd1 ? {{20{i[31]}}, i[31:20]} :
          dec.fmt == 3'd2 ? {{20{i[31]}}, i[31:25], i[11:7]} :
          dec.fmt == 3'd3 ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
          dec.fmt == 3'd4 ? {i[31:12], 12'b0} :
          dec.fmt == 3'd5 ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 32'b0;
    dec.sal = XLEN'($signed(imm));
    dec.ill = dec.fmt == 3'd0;
    acc = bus.valid_i & ready_q;
    drn = out_v_q & bus.ready_i;
    out_d = out_q;
    out_v_d = out_v_q;
    skid_d = skid_q;
    skid_v_d = skid_v_q;
    if (skid_v_q && drn) begin
      out_d = skid_q;
      skid_v_d = 1'b0;
    end else if (acc && (!out_v_q || drn)) begin
      out_d = dec;
      out_v_d = 1'b1;
    end else if (acc) begin
      skid_d = dec;
      skid_v_d = 1'b1;
    end else if (drn) begin
      out_v_d = 1'b0;
    end
    ready_d = !skid_v_d;
    cnt_d = bus.clr_cnt_i ? '0 : (acc && dec.ill && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
    end
  end
  assign bus.ready_o       = ready_q;
  assign bus.valid_o       = out_v_q;
  assign bus.sal_o         = out_q.sal;
  assign bus.fmt_o         = out_q.fmt;
  assign bus.illegal_o     = out_q.ill;
  assign bus.illegal_cnt_o = cnt_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random checks of imm_gen_pipe against a queue-based reference model
module tb_imm_gen_pipe;
  typedef struct {
    logic [63:0] sal;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   cnt_m = 0;
  bit   rdy_m = 1'b0;
  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h00};
  always #5 clk = ~clk;
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(8)) m ();
  imm_gen_pipe_if #(.XLEN(32), .CNT_W(8)) n ();
  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut (.clk_i(clk), .rst_i(rst), .bus(m));
  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (.clk_i(clk), .rst_i(rst), .bus(n));
  assign n.inst_i    = m.inst_i;
  assign n.valid_i   = m.valid_i;
  assign n.ready_i   = m.ready_i;
  assign n.clr_cnt_i = m.clr_cnt_i;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic exp_t ref_dec(logic [31:0] i, int xlen);
    exp_t   e;
    longint v;
    v = 0;
    e.fmt = 3'd0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin v = longint'($signed(i[31:20])); e.fmt = 3'd1; end
      7'h1B: if (xlen == 64) begin v = longint'($signed(i[31:20])); e.fmt = 3'd1; end
      7'h23: begin v = longint'($signed(i[31:25])) * 32 + longint'(i[11:7]); e.fmt = 3'd2; end
      7'h63: begin
        v = (i[31] ? -64'sd4096 : 64'sd0) + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        e.fmt = 3'd3;
      end
      7'h37, 7'h17: begin v = longint'($signed(i[31:12])) * 4096; e.fmt = 3'd4; end
      7'h6F: begin
        v = (i[31] ? -64'sd1048576 : 64'sd0) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        e.fmt = 3'd5;
      end
      default: ;
    endcase
    e.sal = v;
    e.ill = e.fmt == 3'd0;
    return e;
  endfunction
  task automatic check_outs();
    chk("valid_o", m.valid_o, q.size() > 0);
    chk("ready_o", m.ready_o, rdy_m);
    chk("cnt", m.illegal_cnt_o, cnt_m);
    if (q.size() > 0) begin
      chk("sal_o", m.sal_o, q[0].sal);
      chk("fmt_o", m.fmt_o, q[0].fmt);
      chk("illegal_o", m.illegal_o, q[0].ill);
    end
  endtask
  task automatic step();
    exp_t e;
    bit   acc, drn;
    acc = m.valid_i && rdy_m;
    drn = q.size() > 0 && m.ready_i;
    e = ref_dec(m.inst_i, 64);
    if (m.clr_cnt_i) cnt_m = 0;
    else if (acc && e.ill && cnt_m < 255) cnt_m++;
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(e);
    rdy_m = q.size() < 2;
    #1;
    check_outs();
  endtask
  initial begin
    logic [31:0] r;
    m.inst_i = 32'h0;
    m.valid_i = 1'b0;
    m.ready_i = 1'b1;
    m.clr_cnt_i = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", m.valid_o, 0);
    chk("rst_sal", m.sal_o, 0);
    chk("rst_fmt", m.fmt_o, 0);
    chk("rst_ill", m.illegal_o, 0);
    chk("rst_cnt", m.illegal_cnt_o, 0);
    chk("rst_ready", m.ready_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rel_ready0", m.ready_o, 0);
    step();
    chk("rel_ready1", m.ready_o, 1);
    m.valid_i = 1'b1;
    m.inst_i = 32'hFFF00093;
    step();
    chk("addi_sal", m.sal_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_fmt", m.fmt_o, 1);
    m.inst_i = 32'hFE000EE3;
    step();
    chk("beq_sal", m.sal_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_fmt", m.fmt_o, 3);
    m.inst_i = 32'h0010006F;
    step();
    chk("jal_sal", m.sal_o, 64'h800);
    chk("jal_fmt", m.fmt_o, 5);
    m.inst_i = 32'h800000B7;
    step();
    chk("lui64_sal", m.sal_o, 64'hFFFF_FFFF_8000_0000);
    chk("lui32_sal", n.sal_o, 32'h8000_0000);
    chk("lui32_fmt", n.fmt_o, 4);
    m.inst_i = 32'hFFF0809B;
    step();
    chk("addiw64_sal", m.sal_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw64_fmt", m.fmt_o, 1);
    chk("addiw32_ill", n.illegal_o, 1);
    chk("addiw32_sal", n.sal_o, 0);
    chk("addiw32_fmt", n.fmt_o, 0);
    m.valid_i = 1'b0;
    step();
    m.ready_i = 1'b0;
    m.valid_i = 1'b1;
    m.inst_i = 32'hFFF00093;
    step();
    m.inst_i = 32'hFE000EE3;
    step();
    chk("bp_ready_low", m.ready_o, 0);
    m.inst_i = 32'h0010006F;
    step();
    step();
    chk("bp_hold_fmt", m.fmt_o, 1);
    chk("bp_hold_sal", m.sal_o, 64'hFFFF_FFFF_FFFF_FFFF);
    m.ready_i = 1'b1;
    step();
    chk("bp_second_fmt", m.fmt_o, 3);
    chk("bp_ready_back", m.ready_o, 1);
    step();
    chk("bp_third_fmt", m.fmt_o, 5);
    m.valid_i = 1'b0;
    step();
    chk("bp_empty", m.valid_o, 0);
    m.valid_i = 1'b1;
    m.inst_i = 32'h00000033;
    for (int k = 0; k < 300; k++) step();
    chk("sat_cnt", m.illegal_cnt_o, 255);
    chk("sat_ill", m.illegal_o, 1);
    chk("sat_sal", m.sal_o, 0);
    m.clr_cnt_i = 1'b1;
    step();
    chk("clr_prio", m.illegal_cnt_o, 0);
    m.clr_cnt_i = 1'b0;
    for (int k = 0; k < 500; k++) begin
      r = $urandom();
      m.valid_i = $urandom_range(0, 1) == 1;
      m.ready_i = $urandom_range(0, 3) != 0;
      m.clr_cnt_i = $urandom_range(0, 15) == 0;
      m.inst_i = {r[31:7], ops[$urandom_range(0, 11)]};
      step();
    end
    m.clr_cnt_i = 1'b0;
    m.valid_i = 1'b0;
    m.ready_i = 1'b1;
    step();
    step();
    m.ready_i = 1'b0;
    m.valid_i = 1'b1;
    m.inst_i = 32'h00000033;
    step();
    step();
    chk("mid_skid_full", m.ready_o, 0);
    m.valid_i = 1'b0;
    #2 rst = 1'b1;
    q.delete();
    cnt_m = 0;
    rdy_m = 1'b0;
    #1;
    chk("async_valid", m.valid_o, 0);
    chk("async_cnt", m.illegal_cnt_o, 0);
    chk("async_ready", m.ready_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m.ready_i = 1'b1;
    chk("mid_rel_ready0", m.ready_o, 0);
    step();
    chk("mid_rel_ready1", m.ready_o, 1);
    chk("mid_no_replay", m.valid_o, 0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
